align: RTL and testbench

ALIGN -- requirements
Module: align

---
 rtl/align_if.sv | 29 ++
 rtl/align.sv | 81 ++++++++
 tb/tb_align.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/align_if.sv
// Operand/result bundle for the align stage.
//   OP_L  : larger-magnitude operand (sign, exponent, mantissa)
//   OP_S  : smaller-magnitude operand, same format
//   exp   : common (larger) exponent field
//   mat_L : extended significand of OP_L
//   mat_S : extended significand of OP_S, aligned to OP_L, with sticky in bit 0
// master drives the operands and receives results; slave is the align block.
interface align_if #(
  parameter int WIDTH       = 32,
  parameter int WIDTH_exp   = 8,
  parameter int WIDTH_mat   = 23,
  parameter int WIDTH_round = 30
);
  logic [WIDTH-1:0]                 OP_L;
  logic [WIDTH-1:0]                 OP_S;
  logic [WIDTH_exp-1:0]             exp;
  logic [WIDTH_mat+WIDTH_round:0]   mat_L;
  logic [WIDTH_mat+WIDTH_round:0]   mat_S;

  modport master (
    output OP_L, OP_S,
    input  exp, mat_L, mat_S
  );

  modport slave (
    input  OP_L, OP_S,
    output exp, mat_L, mat_S
  );
endinterface

// File: rtl/align.sv
// Single-stage floating-point significand alignment.
// Extracts the significands of the larger (OP_L) and smaller (OP_S) operands,
// appends WIDTH_round zero guard bits, and right-shifts the smaller one by the
// effective exponent difference, collapsing shifted-out ones into a sticky bit 0.
// Results are registered: one cycle latency, one operand pair per cycle.
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset, clears all outputs
//   bus : align_if slave modport (OP_L, OP_S in; exp, mat_L, mat_S out)
module align #(
  parameter int WIDTH       = 32,
  parameter int WIDTH_exp   = 8,
  parameter int WIDTH_mat   = 23,
  parameter int WIDTH_round = 30
) (
  input  logic   CLK,
  input  logic   RST,
  align_if.slave bus
);

  localparam int MW = WIDTH_mat + 1 + WIDTH_round;

  logic [WIDTH_exp-1:0] exp_l, exp_s;
  logic [WIDTH_exp-1:0] eff_l, eff_s;
  logic [WIDTH_exp-1:0] shamt;
  logic                 hid_l, hid_s;
  logic [MW-1:0]        sig_l, sig_s;
  logic [MW-1:0]        lost_mask;
  logic                 sticky;

  logic [WIDTH_exp-1:0] exp_d, exp_q;
  logic [MW-1:0]        mat_l_d, mat_l_q;
  logic [MW-1:0]        mat_s_d, mat_s_q;

  // Signs play no part in alignment.
  logic unused_sign;
  assign unused_sign = bus.OP_L[WIDTH-1] ^ bus.OP_S[WIDTH-1];

  always_comb begin
    exp_l = bus.OP_L[WIDTH-2 -: WIDTH_exp];
    exp_s = bus.OP_S[WIDTH-2 -: WIDTH_exp];

    hid_l = |exp_l;
    hid_s = |exp_s;

    // Denormals share the exponent of the smallest normal.
    eff_l = hid_l ? exp_l : {{(WIDTH_exp-1){1'b0}}, 1'b1};
    eff_s = hid_s ? exp_s : {{(WIDTH_exp-1){1'b0}}, 1'b1};

    shamt = (eff_l >= eff_s) ? (eff_l - eff_s) : '0;

    sig_l = {hid_l, bus.OP_L[WIDTH_mat-1:0], {WIDTH_round{1'b0}}};
    sig_s = {hid_s, bus.OP_S[WIDTH_mat-1:0], {WIDTH_round{1'b0}}};

    // Mask of the bit positions that fall off the bottom; a shift of MW or
    // more yields an all-ones mask, so the sticky covers the whole significand.
    lost_mask = ~({MW{1'b1}} << shamt);
    sticky    = |(sig_s & lost_mask);

    exp_d   = exp_l;
    mat_l_d = sig_l;
    mat_s_d = (sig_s >> shamt) | {{(MW-1){1'b0}}, sticky};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q   <= '0;
      mat_l_q <= '0;
      mat_s_q <= '0;
    end else begin
      exp_q   <= exp_d;
      mat_l_q <= mat_l_d;
      mat_s_q <= mat_s_d;
    end
  end

  assign bus.exp   = exp_q;
  assign bus.mat_L = mat_l_q;
  assign bus.mat_S = mat_s_q;

endmodule

// File: tb/tb_align.sv
module tb_align;

  localparam int MW = 54;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  align_if #(.WIDTH(32), .WIDTH_exp(8), .WIDTH_mat(23), .WIDTH_round(30)) bus ();

  align #(.WIDTH(32), .WIDTH_exp(8), .WIDTH_mat(23), .WIDTH_round(30)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [MW-1:0] b(input int unsigned n);
    b = {{(MW-1){1'b0}}, 1'b1} << n;
  endfunction

  // Drive operands, take one rising edge, and settle 1 time unit past it.
  task automatic apply(input logic [31:0] l, input logic [31:0] s);
    bus.OP_L = l;
    bus.OP_S = s;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    bus.OP_L = $urandom;
    bus.OP_S = $urandom;
    #1;
    checks++;
    if (bus.exp !== 8'd0 || bus.mat_L !== '0 || bus.mat_S !== '0) begin
      errors++;
      $display("FAIL reset_async: exp=%h mat_L=%h mat_S=%h required all 0", bus.exp, bus.mat_L, bus.mat_S);
    end
    for (int i = 0; i < 3; i++) begin
      bus.OP_L = $urandom;
      bus.OP_S = $urandom;
      @(posedge CLK);
      #1;
      checks++;
      if (bus.exp !== 8'd0 || bus.mat_L !== '0 || bus.mat_S !== '0) begin
        errors++;
        $display("FAIL reset_clocked[%0d]: exp=%h mat_L=%h mat_S=%h required all 0", i, bus.exp, bus.mat_L, bus.mat_S);
      end
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_shift;
    logic [31:0]   l [3];
    logic [31:0]   s [3];
    logic [7:0]    e [3];
    logic [MW-1:0] ml[3];
    logic [MW-1:0] ms[3];
    l[0] = 32'h01C80000; s[0] = 32'h01500000; e[0] = 8'd3;
    ml[0] = b(53) | b(52) | b(49); ms[0] = b(52) | b(51) | b(49);
    l[1] = 32'h02480000; s[1] = 32'h01500000; e[1] = 8'd4;
    ml[1] = b(53) | b(52) | b(49); ms[1] = b(51) | b(50) | b(48);
    // Sign bits set on both: must be ignored.
    l[2] = 32'h82480000; s[2] = 32'h81500000; e[2] = 8'd4;
    ml[2] = b(53) | b(52) | b(49); ms[2] = b(51) | b(50) | b(48);
    for (int i = 0; i < 3; i++) begin
      apply(l[i], s[i]);
      checks++;
      if (bus.exp !== e[i] || bus.mat_L !== ml[i] || bus.mat_S !== ms[i]) begin
        errors++;
        $display("FAIL shift[%0d]: exp=%h mat_L=%h mat_S=%h required exp=%h mat_L=%h mat_S=%h",
                 i, bus.exp, bus.mat_L, bus.mat_S, e[i], ml[i], ms[i]);
      end
    end
  endtask

  task automatic test_equal;
    apply(32'h3F800000, 32'h3F800000);
    checks++;
    if (bus.exp !== 8'h7F || bus.mat_L !== b(53) || bus.mat_S !== b(53)) begin
      errors++;
      $display("FAIL equal_exp: exp=%h mat_L=%h mat_S=%h required exp=7f mat_L=mat_S=%h",
               bus.exp, bus.mat_L, bus.mat_S, b(53));
    end
    // effS > effL: shift clamps to zero.
    apply(32'h01000000, 32'h02800000);
    checks++;
    if (bus.exp !== 8'd2 || bus.mat_S !== b(53)) begin
      errors++;
      $display("FAIL neg_shift: exp=%h mat_S=%h required exp=02 mat_S=%h", bus.exp, bus.mat_S, b(53));
    end
  endtask

  task automatic test_sticky;
    logic [31:0]   l [7];
    logic [31:0]   s [7];
    logic [7:0]    e [7];
    logic [MW-1:0] ms[7];
    // d=100, arbitrary mantissa -> sticky only
    l[0] = 32'h64000000; s[0] = 32'h32123456; e[0] = 8'd200; ms[0] = b(0);
    // d=30, OP_S = 1.0
    l[1] = 32'h14000000; s[1] = 32'h05000000; e[1] = 8'd40;  ms[1] = b(23);
    // d=50, mantissa LSB (sig bit 30) lost -> hidden lands at 3 plus sticky
    l[2] = 32'h1E000000; s[2] = 32'h05000001; e[2] = 8'd60;  ms[2] = b(3) | b(0);
    // d=53, hidden lands exactly at bit 0, LSB lost into sticky
    l[3] = 32'h1F800000; s[3] = 32'h05000001; e[3] = 8'd63;  ms[3] = b(0);
    // d=54, first fully-shifted-out case
    l[4] = 32'h20000000; s[4] = 32'h05000000; e[4] = 8'd64;  ms[4] = b(0);
    // zero OP_S with huge shift: no sticky
    l[5] = 32'h64000000; s[5] = 32'h00000000; e[5] = 8'd200; ms[5] = '0;
    // exponent 255 aligned arithmetically, d=128
    l[6] = 32'h7F800000; s[6] = 32'h3F800000; e[6] = 8'hFF;  ms[6] = b(0);
    for (int i = 0; i < 7; i++) begin
      apply(l[i], s[i]);
      checks++;
      if (bus.exp !== e[i] || bus.mat_L !== b(53) || bus.mat_S !== ms[i]) begin
        errors++;
        $display("FAIL sticky[%0d]: exp=%h mat_L=%h mat_S=%h required exp=%h mat_L=%h mat_S=%h",
                 i, bus.exp, bus.mat_L, bus.mat_S, e[i], b(53), ms[i]);
      end
    end
  endtask

  task automatic test_denormal;
    apply(32'h00800000, 32'h00400000);
    checks++;
    if (bus.exp !== 8'd1 || bus.mat_L !== b(53) || bus.mat_S !== b(52)) begin
      errors++;
      $display("FAIL denormal: exp=%h mat_L=%h mat_S=%h required exp=01 mat_L=%h mat_S=%h",
               bus.exp, bus.mat_L, bus.mat_S, b(53), b(52));
    end
    // Zero mantissa/exponent for OP_L: hidden bit 0, empty significand.
    apply(32'h00000000, 32'h00000000);
    checks++;
    if (bus.exp !== 8'd0 || bus.mat_L !== '0 || bus.mat_S !== '0) begin
      errors++;
      $display("FAIL zero_ops: exp=%h mat_L=%h mat_S=%h required all 0", bus.exp, bus.mat_L, bus.mat_S);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0]   l [4];
    logic [31:0]   s [4];
    logic [7:0]    e [4];
    logic [MW-1:0] ml[4];
    logic [MW-1:0] ms[4];
    logic [7:0]    pe;
    logic [MW-1:0] pml, pms;
    l[0] = 32'h01C80000; s[0] = 32'h01500000; e[0] = 8'd3;
    ml[0] = b(53) | b(52) | b(49); ms[0] = b(52) | b(51) | b(49);
    l[1] = 32'h3F800000; s[1] = 32'h3F800000; e[1] = 8'h7F;
    ml[1] = b(53); ms[1] = b(53);
    l[2] = 32'h02480000; s[2] = 32'h01500000; e[2] = 8'd4;
    ml[2] = b(53) | b(52) | b(49); ms[2] = b(51) | b(50) | b(48);
    l[3] = 32'h00800000; s[3] = 32'h00400000; e[3] = 8'd1;
    ml[3] = b(53); ms[3] = b(52);
    apply(32'h14000000, 32'h05000000);
    pe = 8'd40; pml = b(53); pms = b(23);
    for (int i = 0; i < 4; i++) begin
      bus.OP_L = l[i];
      bus.OP_S = s[i];
      #1;
      checks++;
      if (bus.exp !== pe || bus.mat_L !== pml || bus.mat_S !== pms) begin
        errors++;
        $display("FAIL b2b_hold[%0d]: exp=%h mat_L=%h mat_S=%h required exp=%h mat_L=%h mat_S=%h",
                 i, bus.exp, bus.mat_L, bus.mat_S, pe, pml, pms);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (bus.exp !== e[i] || bus.mat_L !== ml[i] || bus.mat_S !== ms[i]) begin
        errors++;
        $display("FAIL b2b[%0d]: exp=%h mat_L=%h mat_S=%h required exp=%h mat_L=%h mat_S=%h",
                 i, bus.exp, bus.mat_L, bus.mat_S, e[i], ml[i], ms[i]);
      end
      pe = e[i]; pml = ml[i]; pms = ms[i];
    end
  endtask

  task automatic test_reset_midstream;
    apply(32'h3F800000, 32'h3F800000);
    checks++;
    if (bus.exp !== 8'h7F) begin
      errors++;
      $display("FAIL mid_pre: exp=%h required 7f", bus.exp);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (bus.exp !== 8'd0 || bus.mat_L !== '0 || bus.mat_S !== '0) begin
      errors++;
      $display("FAIL mid_async: exp=%h mat_L=%h mat_S=%h required all 0", bus.exp, bus.mat_L, bus.mat_S);
    end
    bus.OP_L = 32'h02480000;
    bus.OP_S = 32'h01500000;
    @(posedge CLK);
    #1;
    checks++;
    if (bus.exp !== 8'd0 || bus.mat_L !== '0 || bus.mat_S !== '0) begin
      errors++;
      $display("FAIL mid_held: exp=%h mat_L=%h mat_S=%h required all 0", bus.exp, bus.mat_L, bus.mat_S);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (bus.exp !== 8'd4 || bus.mat_L !== (b(53) | b(52) | b(49)) || bus.mat_S !== (b(51) | b(50) | b(48))) begin
      errors++;
      $display("FAIL mid_release: exp=%h mat_L=%h mat_S=%h required exp=04 mat_L=%h mat_S=%h",
               bus.exp, bus.mat_L, bus.mat_S, b(53) | b(52) | b(49), b(51) | b(50) | b(48));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RST      = 1'b1;
    bus.OP_L = '0;
    bus.OP_S = '0;
    test_reset();
    test_shift();
    test_equal();
    test_sticky();
    test_denormal();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
